// File: rtl/relax_step_sequencer_pkg.sv
// Shared definitions for the relaxation-step sequencer: state encoding and strobe bit positions.
package relax_step_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_STEP = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int STB_LOAD = 0;
    localparam int STB_STEP = 1;
    localparam int STB_DONE = 2;
    localparam int STB_W    = 3;

    // One-hot strobe vector that is high while the FSM sits in state s.
    function automatic logic [STB_W-1:0] strobes_for(input state_e s);
        logic [STB_W-1:0] stb;
        stb = '0;
        case (s)
            ST_LOAD: stb[STB_LOAD] = 1'b1;
            ST_STEP: stb[STB_STEP] = 1'b1;
            ST_DONE: stb[STB_DONE] = 1'b1;
            default: stb = '0;
        endcase
        return stb;
    endfunction

endpackage

// File: rtl/relax_step_sequencer_settle_counter.sv
// Iteration and quiet-response counters; flags settle on the current response and the step limit.
module relax_settle_counter #(
    parameter int MAX_ITERS   = 16,
    parameter int QUIET_ITERS = 3,
    parameter int CW          = 5
) (
    input  logic          eclk,
    input  logic          erst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic          resp,
    input  logic          chg,
    output logic [CW-1:0] it_cnt,
    output logic          settled,
    output logic          limit
);

    logic [CW-1:0] quiet_cnt;
    logic [CW-1:0] q_next;

    assign q_next  = chg ? '0 : quiet_cnt + 1'b1;
    assign settled = resp && (q_next == CW'(QUIET_ITERS));
    assign limit   = (it_cnt == CW'(MAX_ITERS));

    // quiet_cnt drops back to 0 on settle so it never reaches QUIET_ITERS.
    always_ff @(posedge eclk or negedge erst_n) begin
        if (!erst_n) begin
            it_cnt    <= '0;
            quiet_cnt <= '0;
        end else if (clr) begin
            it_cnt    <= '0;
            quiet_cnt <= '0;
        end else begin
            if (inc)
                it_cnt <= it_cnt + 1'b1;
            if (resp)
                quiet_cnt <= settled ? '0 : q_next;
        end
    end

endmodule

// File: rtl/relax_step_sequencer.sv
// Run sequencer for the switch-level relaxation network: load pads, step until settled or limit, sample.
module relax_step_sequencer
    import relax_step_sequencer_pkg::*;
#(
    parameter int MAX_ITERS   = 16,
    parameter int QUIET_ITERS = 3,
    parameter int CW          = 5
) (
    input  logic          eclk,
    input  logic          erst_n,
    input  logic          req,
    input  logic          req_phase,
    input  logic          chg_valid,
    input  logic          chg,
    input  logic          clr_sticky,
    output logic          phase,
    output logic          pad_load,
    output logic          step,
    output logic          sample,
    output logic          ack,
    output logic [CW-1:0] iters,
    output logic          timeout,
    output logic          timeout_sticky
);

    state_e           state, state_nxt;
    logic             resp, settled, limit, run_settled;
    logic [CW-1:0]    it_cnt;
    logic [STB_W-1:0] stb_nxt;

    assign resp    = (state == ST_WAIT) && chg_valid;
    assign stb_nxt = strobes_for(state_nxt);

    relax_settle_counter #(
        .MAX_ITERS  (MAX_ITERS),
        .QUIET_ITERS(QUIET_ITERS),
        .CW         (CW)
    ) u_cnt (
        .eclk   (eclk),
        .erst_n (erst_n),
        .clr    ((state == ST_IDLE) && req),
        .inc    (state == ST_STEP),
        .resp   (resp),
        .chg    (chg),
        .it_cnt (it_cnt),
        .settled(settled),
        .limit  (limit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_STEP;
            ST_STEP: state_nxt = ST_WAIT;
            ST_WAIT: if (resp) state_nxt = (settled || limit) ? ST_DONE : ST_STEP;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are high exactly while in that state.
    always_ff @(posedge eclk or negedge erst_n) begin
        if (!erst_n) begin
            state          <= ST_IDLE;
            phase          <= 1'b0;
            pad_load       <= 1'b0;
            step           <= 1'b0;
            sample         <= 1'b0;
            ack            <= 1'b0;
            iters          <= '0;
            timeout        <= 1'b0;
            timeout_sticky <= 1'b0;
            run_settled    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pad_load <= stb_nxt[STB_LOAD];
            step     <= stb_nxt[STB_STEP];
            sample   <= stb_nxt[STB_DONE];
            ack      <= stb_nxt[STB_DONE];
            if ((state == ST_IDLE) && req)
                phase <= req_phase;
            if (resp)
                run_settled <= settled;
            if (state == ST_DONE) begin
                iters   <= it_cnt;
                timeout <= ~run_settled;
            end
            // A timeout run completing in the same cycle as clr_sticky keeps the flag set.
            if (clr_sticky)
                timeout_sticky <= 1'b0;
            if ((state == ST_DONE) && !run_settled)
                timeout_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_relax_step_sequencer.sv
// Directed plus randomized runs against a step-count model derived from the settle/limit rules.
module tb_relax_step_sequencer;

    localparam int MAX   = 16;
    localparam int QUIET = 3;
    localparam int CW    = 5;

    logic          eclk = 1'b0;
    logic          erst_n, req, req_phase, chg_valid, chg, clr_sticky;
    logic          phase, pad_load, step, sample, ack, timeout, timeout_sticky;
    logic [CW-1:0] iters;

    int  vecs = 0;
    int  errs = 0;
    bit  sticky_m = 1'b0;

    always #5 eclk = ~eclk;

    relax_step_sequencer #(.MAX_ITERS(MAX), .QUIET_ITERS(QUIET), .CW(CW)) dut (
        .eclk(eclk), .erst_n(erst_n), .req(req), .req_phase(req_phase),
        .chg_valid(chg_valid), .chg(chg), .clr_sticky(clr_sticky),
        .phase(phase), .pad_load(pad_load), .step(step), .sample(sample), .ack(ack),
        .iters(iters), .timeout(timeout), .timeout_sticky(timeout_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response s (1-based) reports pat[s-1]; count steps until QUIET quiet responses or MAX steps.
    task automatic model(input bit [31:0] pat, output int n, output bit to);
        int  q;
        bit  done;
        q = 0; n = MAX; to = 1'b1; done = 1'b0;
        for (int s = 1; s <= MAX; s++) begin
            if (!done) begin
                q = pat[s-1] ? 0 : q + 1;
                if (q == QUIET) begin
                    n = s; to = 1'b0; done = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input string tag, input bit [31:0] pat, input bit ph,
                       input bit early_drop, input bit stray_step, input bit clr_at_done);
        int  n_exp, steps;
        bit  to_exp, pend, got_ack;
        model(pat, n_exp, to_exp);
        @(negedge eclk);
        req = 1'b1; req_phase = ph;
        @(negedge eclk);
        chk({tag, ".pad_load"}, pad_load, 1);
        chk({tag, ".phase"}, phase, ph);
        if (early_drop) req = 1'b0;
        steps = 0; pend = 1'b0; got_ack = 1'b0;
        for (int i = 1; i <= 60 && !got_ack; i++) begin
            @(negedge eclk);
            chg_valid = 1'b0; clr_sticky = 1'b0;
            if (pend) begin
                chg_valid = 1'b1; chg = pat[steps-1]; pend = 1'b0;
            end
            if (step) begin
                steps++; pend = 1'b1;
                if (stray_step) begin
                    chg_valid = 1'b1; chg = ~pat[steps-1];
                end
            end
            if (ack) begin
                got_ack = 1'b1;
                chk({tag, ".ack_cycle"}, i, 2 * n_exp + 1);
                chk({tag, ".sample"}, sample, 1);
                req = 1'b0;
                if (clr_at_done) clr_sticky = 1'b1;
            end
        end
        chk({tag, ".got_ack"}, got_ack, 1);
        chk({tag, ".steps"}, steps, n_exp);
        @(negedge eclk);
        chg_valid = 1'b0; clr_sticky = 1'b0;
        if (to_exp) sticky_m = 1'b1;
        else if (clr_at_done) sticky_m = 1'b0;
        chk({tag, ".iters"}, iters, n_exp);
        chk({tag, ".timeout"}, timeout, to_exp);
        chk({tag, ".sticky"}, timeout_sticky, sticky_m);
        chk({tag, ".ack_low"}, ack, 0);
    endtask

    initial begin
        erst_n = 1'b0; req = 1'b0; req_phase = 1'b0;
        chg_valid = 1'b0; chg = 1'b0; clr_sticky = 1'b0;
        @(negedge eclk);
        chk("rst.outs", {phase, pad_load, step, sample, ack, timeout, timeout_sticky}, 0);
        chk("rst.iters", iters, 0);
        @(negedge eclk);
        erst_n = 1'b1;

        // 1: quiet network settles after QUIET steps
        run("t1", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        // 2: five changes then quiet -> 8 steps
        run("t2", 32'h1F, 1'b0, 1'b0, 1'b0, 1'b0);
        // 3: never settles -> timeout, sticky survives a settling run, then cleared
        run("t3a", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run("t3b", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge eclk); clr_sticky = 1'b1;
        @(negedge eclk); clr_sticky = 1'b0; sticky_m = 1'b0;
        chk("t3.clr", timeout_sticky, 0);
        // 4: settles on the last allowed step
        run("t4", 32'h1FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // 5: reset during WAIT
        @(negedge eclk); req = 1'b1; req_phase = 1'b1;
        for (int i = 0; i < 10 && !step; i++) @(negedge eclk);
        req = 1'b0;
        chk("t5.step_seen", step, 1);
        @(negedge eclk);
        erst_n = 1'b0;
        #1;
        chk("t5.outs", {phase, pad_load, step, sample, ack, timeout, timeout_sticky}, 0);
        chk("t5.iters", iters, 0);
        sticky_m = 1'b0;
        @(negedge eclk); erst_n = 1'b1;
        run("t5r", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: stray chg_valid in IDLE and STEP, clr_sticky coinciding with timeout DONE
        @(negedge eclk); chg_valid = 1'b1; chg = 1'b1;
        @(negedge eclk); chg_valid = 1'b0;
        chk("t6.idle_stray", {pad_load, step, ack}, 0);
        run("t6", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        run("t6b", 32'h6, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 24; r++) begin
            bit [31:0] p;
            p = $urandom & $urandom;
            if (r % 4 == 3) p = $urandom | $urandom | $urandom;
            run("rnd", p, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
